// File: rtl/key_pkg.sv
// Shared state encodings, width helper and 50 MHz timing defaults for the key debouncer.
package key_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HELD    = 2'd1;
    localparam logic [1:0] ST_LONG    = 2'd2;
    localparam logic [1:0] ST_REL_CHK = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        HELD    = ST_HELD,
        LONG    = ST_LONG,
        REL_CHK = ST_REL_CHK
    } key_state_e;

    localparam int DEF_MASK_TIME   = 500_000;
    localparam int DEF_LONG_TIME   = 50_000_000;
    localparam int DEF_REPEAT_TIME = 10_000_000;

    // Never returns 0, so a counter sized from it always has at least one bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/key_debounce_multi_if.sv
// Key pins and debounced event outputs for all channels, grouped for the debouncer.
interface key_debounce_multi_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_n;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_long;
    logic [NUM_KEYS-1:0] key_repeat;

    modport master (
        output key_n,
        input  key_level, key_press, key_release, key_long, key_repeat
    );

    modport slave (
        input  key_n,
        output key_level, key_press, key_release, key_long, key_repeat
    );
endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: synchronizer, debounce/hold FSM and its two counters.
//   state   | meaning
//   IDLE    | released, counting consecutive pressed samples
//   HELD    | pressed, counting towards the long-press time
//   LONG    | long press seen, counting repeat intervals
//   REL_CHK | released samples being confirmed, hold count frozen
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int MASK_TIME   = DEF_MASK_TIME,
    parameter int LONG_TIME   = DEF_LONG_TIME,
    parameter int REPEAT_TIME = DEF_REPEAT_TIME
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o
);

    localparam int DW       = clog2(MASK_TIME + 1);
    localparam int HOLD_MAX = (LONG_TIME > REPEAT_TIME) ? LONG_TIME : REPEAT_TIME;
    localparam int HW       = clog2(HOLD_MAX + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(MASK_TIME - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_TIME - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_TIME - 1);
    localparam logic [HW-1:0] HOLD_SAT  = '1;

    logic [1:0]    sync_q;
    key_state_e    state_q, state_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [HW-1:0] hold_q, hold_d, hold_inc;
    logic          long_seen_q, long_seen_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          repeat_q, repeat_d;
    logic          p;

    assign p        = ~sync_q[1];
    assign hold_inc = (hold_q == HOLD_SAT) ? hold_q : hold_q + HW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= 2'b11;
            state_q     <= IDLE;
            deb_q       <= '0;
            hold_q      <= '0;
            long_seen_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], key_n_i};
            state_q     <= state_d;
            deb_q       <= deb_d;
            hold_q      <= hold_d;
            long_seen_q <= long_seen_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        deb_d       = deb_q;
        hold_d      = hold_q;
        long_seen_d = long_seen_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        repeat_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!p) begin
                    deb_d = '0;
                end else if (deb_q == DEB_LAST) begin
                    state_d = HELD;
                    press_d = 1'b1;
                    deb_d   = '0;
                    hold_d  = '0;
                end else begin
                    deb_d = deb_q + DW'(1);
                end
            end
            HELD: begin
                if (!p) begin
                    state_d = REL_CHK;
                    deb_d   = DW'(1);
                end else if (LONG_TIME != 0 && hold_q == LONG_LAST) begin
                    state_d     = LONG;
                    long_d      = 1'b1;
                    long_seen_d = 1'b1;
                    hold_d      = '0;
                end else begin
                    hold_d = hold_inc;
                end
            end
            LONG: begin
                if (!p) begin
                    state_d = REL_CHK;
                    deb_d   = DW'(1);
                end else if (REPEAT_TIME != 0 && hold_q == REP_LAST) begin
                    repeat_d = 1'b1;
                    hold_d   = '0;
                end else begin
                    hold_d = hold_inc;
                end
            end
            REL_CHK: begin
                // A bounce back to pressed resumes the hold count where it was frozen.
                if (p) begin
                    deb_d   = '0;
                    state_d = long_seen_q ? LONG : HELD;
                end else if (deb_q == DEB_LAST) begin
                    state_d     = IDLE;
                    release_d   = 1'b1;
                    long_seen_d = 1'b0;
                    deb_d       = '0;
                end else begin
                    deb_d = deb_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        level_d = (state_d != IDLE);
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
    assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-key debouncer and gesture detector: one independent channel per key bit.
module key_debounce_multi
    import key_pkg::*;
#(
    parameter int NUM_KEYS    = 4,
    parameter int MASK_TIME   = DEF_MASK_TIME,
    parameter int LONG_TIME   = DEF_LONG_TIME,
    parameter int REPEAT_TIME = DEF_REPEAT_TIME
) (
    input logic                 clk,
    input logic                 rst,
    key_debounce_multi_if.slave keys
);

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
        key_debounce_ch #(
            .MASK_TIME   (MASK_TIME),
            .LONG_TIME   (LONG_TIME),
            .REPEAT_TIME (REPEAT_TIME)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .key_n_i   (keys.key_n[k]),
            .level_o   (keys.key_level[k]),
            .press_o   (keys.key_press[k]),
            .release_o (keys.key_release[k]),
            .long_o    (keys.key_long[k]),
            .repeat_o  (keys.key_repeat[k])
        );
    end

endmodule
